// File: rtl/stack_op_sequencer_pkg.sv
// Shared definitions for the stack operation sequencer: state encoding,
// memory word-select codes, op priority encoding and per-op iteration plans.
package stack_op_sequencer_pkg;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_07FF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SECOND = 2'd1,
        ST_THIRD  = 2'd2
    } state_t;

    localparam logic [1:0] WS_DATA  = 2'd0;
    localparam logic [1:0] WS_PC_HI = 2'd1;
    localparam logic [1:0] WS_PC_LO = 2'd2;
    localparam logic [1:0] WS_FLAGS = 2'd3;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_RTI  = 3'd5,
        OP_INT  = 3'd6
    } op_t;

    // Priority INT > RTI > RET > CALL > POP > PUSH.
    function automatic op_t op_select(input logic push, input logic pop,
                                      input logic call, input logic ret,
                                      input logic rti,  input logic intr);
        op_t op;
        if (intr)      op = OP_INT;
        else if (rti)  op = OP_RTI;
        else if (ret)  op = OP_RET;
        else if (call) op = OP_CALL;
        else if (pop)  op = OP_POP;
        else if (push) op = OP_PUSH;
        else           op = OP_NONE;
        return op;
    endfunction

    function automatic logic op_multi(input logic [5:0] bits);
        return (bits & (bits - 6'd1)) != 6'd0;
    endfunction

    // Index of the final iteration of an op's plan.
    function automatic logic [1:0] op_last_iter(input op_t op);
        logic [1:0] last;
        case (op)
            OP_CALL, OP_RET: last = 2'd1;
            OP_INT, OP_RTI:  last = 2'd2;
            default:         last = 2'd0;
        endcase
        return last;
    endfunction

    function automatic logic op_is_push(input op_t op);
        return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
    endfunction

    // Pops replay the push order backwards so that the stack unwinds cleanly.
    function automatic logic [1:0] op_word_sel(input op_t op, input logic [1:0] iter);
        logic [1:0] ws;
        case (op)
            OP_CALL: ws = (iter == 2'd0) ? WS_PC_HI : WS_PC_LO;
            OP_RET:  ws = (iter == 2'd0) ? WS_PC_LO : WS_PC_HI;
            OP_INT:  ws = (iter == 2'd0) ? WS_PC_HI :
                          (iter == 2'd1) ? WS_PC_LO : WS_FLAGS;
            OP_RTI:  ws = (iter == 2'd0) ? WS_FLAGS :
                          (iter == 2'd1) ? WS_PC_LO : WS_PC_HI;
            default: ws = WS_DATA;
        endcase
        return ws;
    endfunction

endpackage

// File: rtl/register_generic.sv
// Generic enabled register with asynchronous active-high reset.
// Ports: clk, rst, en (load enable), d (next value), q (registered value).
module register_generic #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= RESET_VALUE;
        else if (en) q <= d;
    end

endmodule

// File: rtl/stack_op_sequencer_sp.sv
// Stack pointer: register plus inc/dec adder, wrapping modulo 2^SP_WIDTH.
// Ports: clk, rst, en (iteration advance), dec (1 = push, 0 = pop),
//        sp (registered SP), sp_inc (SP+1, used as the pop address).
module stack_op_sequencer_sp #(
    parameter int                  SP_WIDTH = 32,
    parameter logic [SP_WIDTH-1:0] SP_INIT  = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                dec,
    output logic [SP_WIDTH-1:0] sp,
    output logic [SP_WIDTH-1:0] sp_inc
);

    logic [SP_WIDTH-1:0] sp_dec;
    logic [SP_WIDTH-1:0] sp_nxt;

    assign sp_inc = sp + SP_WIDTH'(1);
    assign sp_dec = sp - SP_WIDTH'(1);
    assign sp_nxt = dec ? sp_dec : sp_inc;

    register_generic #(
        .WIDTH       (SP_WIDTH),
        .RESET_VALUE (SP_INIT)
    ) u_sp_reg (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (sp_nxt),
        .q   (sp)
    );

endmodule

// File: rtl/stack_op_sequencer.sv
// Multi-cycle stack traffic controller between execute and memory stages.
// Splits PC/flag save and restore into 16-bit iterations and owns SP.
//
//   state  | meaning
//   IDLE   | waiting; iteration 0 of an accepted op runs here combinationally
//   SECOND | iteration 1 of a CALL/RET/INT/RTI, op taken from op_q
//   THIRD  | iteration 2 of an INT/RTI, op taken from op_q
//
// Ports: CLK, Reset (async, active-high), Start + op bits (PUSH/POP/CALL/
// RET/RTI/INT), Hold (memory not ready). Outputs Stall, ScndIteration,
// Iter, MemAddr, WordSel, MemWr, MemRd, SpOut, Busy, PrvsStackOp, ErrMulti.
module stack_op_sequencer
    import stack_op_sequencer_pkg::*;
#(
    parameter int                  SP_WIDTH = 32,
    parameter logic [SP_WIDTH-1:0] SP_INIT  = SP_WIDTH'(SP_INIT_DEFAULT)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Start,
    input  logic                PUSH,
    input  logic                POP,
    input  logic                CALL,
    input  logic                RET,
    input  logic                RTI,
    input  logic                INT,
    input  logic                Hold,
    output logic                Stall,
    output logic                ScndIteration,
    output logic [1:0]          Iter,
    output logic [SP_WIDTH-1:0] MemAddr,
    output logic [1:0]          WordSel,
    output logic                MemWr,
    output logic                MemRd,
    output logic [SP_WIDTH-1:0] SpOut,
    output logic                Busy,
    output logic                PrvsStackOp,
    output logic                ErrMulti
);

    state_t              state, state_nxt;
    op_t                 op_q;
    op_t                 op_in;
    op_t                 cur_op;
    logic                active;
    logic                advance;
    logic                is_last;
    logic                is_push;
    logic                accept;
    logic [SP_WIDTH-1:0] sp;
    logic [SP_WIDTH-1:0] sp_inc;

    assign op_in = op_select(PUSH, POP, CALL, RET, RTI, INT);

    stack_op_sequencer_sp #(
        .SP_WIDTH (SP_WIDTH),
        .SP_INIT  (SP_INIT)
    ) u_sp (
        .clk    (CLK),
        .rst    (Reset),
        .en     (advance),
        .dec    (is_push),
        .sp     (sp),
        .sp_inc (sp_inc)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_NONE;
            PrvsStackOp <= 1'b0;
            ErrMulti    <= 1'b0;
        end else begin
            state       <= state_nxt;
            PrvsStackOp <= advance & is_last;
            if (accept) begin
                op_q <= op_in;
                if (op_multi({INT, RTI, RET, CALL, POP, PUSH})) ErrMulti <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_op    = op_in;
        active    = 1'b0;
        Iter      = 2'd0;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                cur_op = op_in;
                active = Start & (op_in != OP_NONE);
                Iter   = 2'd0;
            end
            ST_SECOND: begin
                cur_op = op_q;
                active = 1'b1;
                Iter   = 2'd1;
            end
            ST_THIRD: begin
                cur_op = op_q;
                active = 1'b1;
                Iter   = 2'd2;
            end
            default: begin
                cur_op = OP_NONE;
                active = 1'b0;
                Iter   = 2'd0;
            end
        endcase

        is_last = (Iter == op_last_iter(cur_op));
        is_push = op_is_push(cur_op);
        advance = active & ~Hold;
        accept  = advance & (state == ST_IDLE);

        if (advance) begin
            if (is_last)                 state_nxt = ST_IDLE;
            else if (state == ST_IDLE)   state_nxt = ST_SECOND;
            else if (state == ST_SECOND) state_nxt = ST_THIRD;
            else                         state_nxt = ST_IDLE;
        end

        MemAddr       = active ? (is_push ? sp : sp_inc) : '0;
        WordSel       = active ? op_word_sel(cur_op, Iter) : WS_DATA;
        MemWr         = advance & is_push;
        MemRd         = advance & ~is_push;
        Stall         = Hold | (active & ~is_last);
        ScndIteration = (Iter != 2'd0);
        Busy          = (state != ST_IDLE);
        SpOut         = sp;
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
module tb_stack_op_sequencer;

    localparam logic [5:0] M_PUSH = 6'b000001;
    localparam logic [5:0] M_POP  = 6'b000010;
    localparam logic [5:0] M_CALL = 6'b000100;
    localparam logic [5:0] M_RET  = 6'b001000;
    localparam logic [5:0] M_RTI  = 6'b010000;
    localparam logic [5:0] M_INT  = 6'b100000;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  ws;
        logic        wr;
        logic [1:0]  iter;
        logic        stall;
    } txn_t;

    logic        clk, reset, start, push, pop, call, ret, rti, intr, hold;
    logic        stall, scnd, mem_wr, mem_rd, busy, prvs, err_multi;
    logic [1:0]  iter, word_sel;
    logic [31:0] mem_addr, sp_out;

    int   n_cmp = 0;
    int   n_err = 0;
    txn_t sb[$];

    stack_op_sequencer dut (
        .CLK           (clk),
        .Reset         (reset),
        .Start         (start),
        .PUSH          (push),
        .POP           (pop),
        .CALL          (call),
        .RET           (ret),
        .RTI           (rti),
        .INT           (intr),
        .Hold          (hold),
        .Stall         (stall),
        .ScndIteration (scnd),
        .Iter          (iter),
        .MemAddr       (mem_addr),
        .WordSel       (word_sel),
        .MemWr         (mem_wr),
        .MemRd         (mem_rd),
        .SpOut         (sp_out),
        .Busy          (busy),
        .PrvsStackOp   (prvs),
        .ErrMulti      (err_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input logic [31:0] addr, input logic [1:0] ws, input logic wr,
                              input logic [1:0] it, input logic stl);
        txn_t t;
        t.addr = addr; t.ws = ws; t.wr = wr; t.iter = it; t.stall = stl;
        sb.push_back(t);
    endtask

    // Monitor: every memory iteration seen on the bus is matched against the scoreboard.
    always @(negedge clk) begin
        if (mem_wr || mem_rd) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_txn: got addr 0x%08h wr %0b rd %0b, expected no transaction",
                         mem_addr, mem_wr, mem_rd);
            end else begin
                txn_t e;
                e = sb.pop_front();
                chk("txn_addr",  mem_addr, e.addr);
                chk("txn_ws",    32'(word_sel), 32'(e.ws));
                chk("txn_wr",    32'(mem_wr), 32'(e.wr));
                chk("txn_rd",    32'(mem_rd), 32'(!e.wr));
                chk("txn_iter",  32'(iter), 32'(e.iter));
                chk("txn_scnd",  32'(scnd), 32'(e.iter != 2'd0));
                chk("txn_stall", 32'(stall), 32'(e.stall));
            end
        end
    end

    task automatic drive_ops(input logic [5:0] ops);
        {intr, rti, ret, call, pop, push} = ops;
    endtask

    // Starts at posedge+1, returns at posedge+1 of the completion cycle.
    task automatic issue(input logic [5:0] ops, input int n, input logic [31:0] exp_sp);
        start = 1'b1;
        drive_ops(ops);
        repeat (n) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            drive_ops(6'b0);
        end
        chk("done_prvs", 32'(prvs), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_sp",   sp_out, exp_sp);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        hold  = 1'b0;
        drive_ops(6'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        drive_ops(6'b0);
        #2;
        chk("rst_sp",    sp_out, 32'h7FF);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_prvs",  32'(prvs), 32'd0);
        chk("rst_err",   32'(err_multi), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wr",    32'(mem_wr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // PUSH
        expect_txn(32'h7FF, 2'd0, 1'b1, 2'd0, 1'b0);
        issue(M_PUSH, 1, 32'h7FE);
        idle_cycle();
        chk("idle_prvs", 32'(prvs), 32'd0);

        // CALL from fresh SP
        do_reset();
        expect_txn(32'h7FF, 2'd1, 1'b1, 2'd0, 1'b1);
        expect_txn(32'h7FE, 2'd2, 1'b1, 2'd1, 1'b0);
        issue(M_CALL, 2, 32'h7FD);

        // INT then RTI back-to-back
        do_reset();
        expect_txn(32'h7FF, 2'd1, 1'b1, 2'd0, 1'b1);
        expect_txn(32'h7FE, 2'd2, 1'b1, 2'd1, 1'b1);
        expect_txn(32'h7FD, 2'd3, 1'b1, 2'd2, 1'b0);
        issue(M_INT, 3, 32'h7FC);
        expect_txn(32'h7FD, 2'd3, 1'b0, 2'd0, 1'b1);
        expect_txn(32'h7FE, 2'd2, 1'b0, 2'd1, 1'b1);
        expect_txn(32'h7FF, 2'd1, 1'b0, 2'd2, 1'b0);
        issue(M_RTI, 3, 32'h7FF);
        // RET after CALL
        expect_txn(32'h7FF, 2'd1, 1'b1, 2'd0, 1'b1);
        expect_txn(32'h7FE, 2'd2, 1'b1, 2'd1, 1'b0);
        issue(M_CALL, 2, 32'h7FD);
        expect_txn(32'h7FE, 2'd2, 1'b0, 2'd0, 1'b1);
        expect_txn(32'h7FF, 2'd1, 1'b0, 2'd1, 1'b0);
        issue(M_RET, 2, 32'h7FF);

        // Hold during CALL iteration 1
        do_reset();
        expect_txn(32'h7FF, 2'd1, 1'b1, 2'd0, 1'b1);
        start = 1'b1;
        drive_ops(M_CALL);
        @(posedge clk);
        #1;
        start = 1'b0;
        drive_ops(6'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_addr",  mem_addr, 32'h7FE);
            chk("hold_wr",    32'(mem_wr), 32'd0);
            chk("hold_stall", 32'(stall), 32'd1);
            chk("hold_sp",    sp_out, 32'h7FE);
            chk("hold_iter",  32'(iter), 32'd1);
            chk("hold_ws",    32'(word_sel), 32'd2);
            chk("hold_prvs",  32'(prvs), 32'd0);
            @(posedge clk);
            #1;
        end
        expect_txn(32'h7FE, 2'd2, 1'b1, 2'd1, 1'b0);
        hold = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_done_sp",   sp_out, 32'h7FD);
        chk("hold_done_prvs", 32'(prvs), 32'd1);
        chk("hold_done_busy", 32'(busy), 32'd0);

        // Reset mid-RTI in THIRD
        do_reset();
        expect_txn(32'h800, 2'd3, 1'b0, 2'd0, 1'b1);
        expect_txn(32'h801, 2'd2, 1'b0, 2'd1, 1'b1);
        start = 1'b1;
        drive_ops(M_RTI);
        @(posedge clk);
        #1;
        start = 1'b0;
        drive_ops(6'b0);
        @(posedge clk);
        #1;
        chk("rti3_busy", 32'(busy), 32'd1);
        chk("rti3_iter", 32'(iter), 32'd2);
        reset = 1'b1;
        #1;
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_iter",  32'(iter), 32'd0);
        chk("midrst_sp",    sp_out, 32'h7FF);
        chk("midrst_rd",    32'(mem_rd), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Multiple op bits: POP wins, ErrMulti sticky
        expect_txn(32'h800, 2'd0, 1'b0, 2'd0, 1'b0);
        issue(M_PUSH | M_POP, 1, 32'h800);
        chk("multi_err", 32'(err_multi), 32'd1);
        idle_cycle();
        expect_txn(32'h800, 2'd0, 1'b1, 2'd0, 1'b0);
        issue(M_PUSH, 1, 32'h7FF);
        chk("multi_err_sticky", 32'(err_multi), 32'd1);
        do_reset();
        chk("multi_err_clr", 32'(err_multi), 32'd0);

        // Wrap: 2048 pushes take SP from 0x7FF through 0 to all-ones, then POP wraps to 0
        for (int i = 0; i < 2048; i++) begin
            expect_txn(32'h7FF - 32'(i), 2'd0, 1'b1, 2'd0, 1'b0);
            start = 1'b1;
            drive_ops(M_PUSH);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        drive_ops(6'b0);
        chk("wrap_dec_sp", sp_out, 32'hFFFF_FFFF);
        expect_txn(32'h0, 2'd0, 1'b0, 2'd0, 1'b0);
        issue(M_POP, 1, 32'h0);

        idle_cycle();
        idle_cycle();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Multi-cycle controller for all stack traffic between the execute and memory stages.
- Owns the stack pointer (SP) and splits 32-bit PC and flag save/restore into 16-bit memory iterations.
- Drives ScndIteration, fetch/decode stall, stack address and word-select for the memory stage.
- Drives PrvsStackOp back to decode, replacing the tied-off constant currently used there.

Parameters:
- SP_WIDTH, 32, stack pointer and stack address width.
- SP_INIT, 32'h0000_07FF, SP value after reset (top of data memory).

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- Start  input  1  a stack operation is present in execute this cycle.
- PUSH, POP, CALL, RET, RTI, INT  input  1 each  op bits from the control word or interrupt logic; expected one-hot.
- Hold  input  1  memory stage not ready; freezes the sequencer.
- Stall  output  1  freeze fetch/decode and hold the execute latch.
- ScndIteration  output  1  current cycle is a non-first iteration.
- Iter  output  2  current iteration index, 0..2.
- MemAddr  output  SP_WIDTH  stack address for this iteration.
- WordSel  output  2  memory data selector: 0=Rsrc data, 1=PC[31:16], 2=PC[15:0], 3=flags.
- MemWr  output  1  stack write this iteration.
- MemRd  output  1  stack read this iteration.
- SpOut  output  SP_WIDTH  registered SP.
- Busy  output  1  sequencer is not in IDLE.
- PrvsStackOp  output  1  a stack op completed last cycle.
- ErrMulti  output  1  sticky: more than one op bit was seen at accept.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation): state=IDLE, SP=SP_INIT, op register cleared, PrvsStackOp=0, ErrMulti=0. All combinational outputs evaluate to 0 with Start=0.
- States:
  - IDLE, SECOND, THIRD.
  - Accept happens in IDLE when Start=1, Hold=0 and any op bit is set. The op is latched in op_q.
  - Iteration 0 executes in the accept cycle itself, combinational from the inputs; there is no added latency.
- Multiple op bits at accept: priority INT > RTI > RET > CALL > POP > PUSH. ErrMulti is set and stays set until reset.
- Iteration plans (push = write at SP, then SP-1; pop = SP+1, then read at the new SP):
  - PUSH: 1 iteration, push WordSel 0.
  - POP: 1 iteration, pop; the destination is written back by the memory stage.
  - CALL: push WS1, then push WS2.
  - RET: pop WS2, then pop WS1.
  - INT: push WS1, then WS2, then WS3.
  - RTI: pop WS3, then WS2, then WS1.
- Pop address: MemAddr = SP+1, using the pre-increment value.
- Transitions:
  - IDLE -> SECOND if the plan has 2 or more iterations.
  - SECOND -> THIRD for INT/RTI; otherwise SECOND -> IDLE.
  - THIRD -> IDLE.
  - 1-iteration ops stay in IDLE.
- In SECOND/THIRD the op comes from op_q; Start and the op inputs are ignored.
- Stall=1 whenever the current iteration is not the last one of its plan. This includes the accept cycle of a multi-iteration op.
- ScndIteration = (Iter != 0).
- Busy = (state != IDLE).
- Hold=1:
  - No state, SP or op_q change.
  - MemWr/MemRd are forced to 0.
  - MemAddr, WordSel, Iter are held stable.
  - Stall is forced to 1.
- SP arithmetic is modulo 2^SP_WIDTH. Decrement from 0 gives all-ones; increment from all-ones gives 0. There is no error flag for wrap.
- PrvsStackOp is registered and is 1 for exactly the cycle after the final, un-held iteration of any op.
- Start in the cycle after completion is accepted normally, giving back-to-back ops.

Decomposition:
- Shared package:
  - State encoding (IDLE/SECOND/THIRD).
  - WordSel codes (WS_DATA, WS_PC_HI, WS_PC_LO, WS_FLAGS).
  - Op priority encoding.
  - SP_INIT default.
- One natural sub-module: the SP register, implemented with the existing register_generic (width SP_WIDTH, enable = iteration advance) plus an inc/dec adder.

Test Plan:
- Reset -> SpOut=0x7FF; Stall=Busy=PrvsStackOp=ErrMulti=0.
- Start+PUSH for 1 cycle -> that cycle MemAddr=0x7FF, WordSel=0, MemWr=1, Stall=0. Next cycle SpOut=0x7FE, PrvsStackOp=1.
- Start+CALL -> cycle0: MemAddr=0x7FF, WS1, Stall=1. Cycle1: ScndIteration=1, MemAddr=0x7FE, WS2, Stall=0. Then SpOut=0x7FD, Busy=0.
- INT then RTI:
  - INT writes 0x7FF/WS1, 0x7FE/WS2, 0x7FD/WS3.
  - RTI reads 0x7FD/WS3, 0x7FE/WS2, 0x7FF/WS1.
  - SpOut ends at 0x7FF.
- Hold=1 for 3 cycles during CALL iteration 1 -> MemAddr stays 0x7FE, MemWr=0, Stall=1, SpOut stays 0x7FE. Release completes normally.
- Reset asserted mid-RTI THIRD -> immediate IDLE, SpOut=0x7FF. Also: POP with SP=0xFFFF_FFFF -> MemAddr=0x0, SpOut=0x0. Start+PUSH+POP together -> POP executed, ErrMulti=1 sticky.
